// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - bundle of master-side and device-side IO bus signals for io_bus_arbiter
//
// Signals:
//   m0_*/m1_*   : requester ports (addr, dout, addr_valid, dout_write in; din, din_ready out)
//   io_*        : device-side bus (addr, dout, write, valid out; din, ready in)
//   grant       : master owning the current/last access
//   err_flag    : sticky timeout flag, err_clr clears it
// Modports:
//   slave  : the arbiter's view (serves the two masters and drives the device bus)
//   master : the environment's view (requesters plus the device)

interface io_bus_arbiter_if;
    logic [63:0] m0_addr;
    logic [63:0] m1_addr;
    logic [63:0] m0_dout;
    logic [63:0] m1_dout;
    logic        m0_addr_valid;
    logic        m1_addr_valid;
    logic        m0_dout_write;
    logic        m1_dout_write;
    logic [63:0] m0_din;
    logic [63:0] m1_din;
    logic        m0_din_ready;
    logic        m1_din_ready;
    logic [63:0] io_addr;
    logic [63:0] io_dout;
    logic        io_write;
    logic        io_valid;
    logic [63:0] io_din;
    logic        io_ready;
    logic        grant;
    logic        err_flag;
    logic        err_clr;

    modport slave (
        input  m0_addr, m1_addr, m0_dout, m1_dout,
        input  m0_addr_valid, m1_addr_valid, m0_dout_write, m1_dout_write,
        output m0_din, m1_din, m0_din_ready, m1_din_ready,
        output io_addr, io_dout, io_write, io_valid,
        input  io_din, io_ready,
        output grant, err_flag,
        input  err_clr
    );

    modport master (
        output m0_addr, m1_addr, m0_dout, m1_dout,
        output m0_addr_valid, m1_addr_valid, m0_dout_write, m1_dout_write,
        input  m0_din, m1_din, m0_din_ready, m1_din_ready,
        input  io_addr, io_dout, io_write, io_valid,
        output io_din, io_ready,
        input  grant, err_flag,
        output err_clr
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin arbiter and sequencer for the external IO bus
//
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : io_bus_arbiter_if.slave (master request/response ports, device bus, grant, err_flag/err_clr)
// Parameters:
//   TIMEOUT_CYCLES : ACTIVE cycles before a hung access is aborted (2..65535)
// Optional feature:
//   IO_BUS_ARB_TIMEOUT_EN : when defined, hung accesses abort with all-ones data and set err_flag;
//                           when undefined, ACTIVE waits indefinitely and err_flag is tied 0.

module io_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    io_bus_arbiter_if.slave  bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("io_bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sel;
    logic        last_grant;
    logic        grant_q;
    logic [63:0] io_addr_q;
    logic [63:0] io_dout_q;
    logic        io_write_q;
    logic        io_valid_q;
    logic [63:0] m0_din_q;
    logic [63:0] m1_din_q;
    logic        abort;
    logic        err_flag_q;
    logic [63:0] cap_data;

    // Round-robin: under contention the master not served last wins;
    // a lone requester always wins.
    always_comb begin
        state_next = state;
        sel        = 1'b0;
        if (bus.m0_addr_valid && bus.m1_addr_valid) begin
            sel = ~last_grant;
        end else begin
            sel = bus.m1_addr_valid;
        end
        case (state)
            IDLE: begin
                if (bus.m0_addr_valid || bus.m1_addr_valid) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.io_ready || abort) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // An aborted access returns all ones; io_ready in the abort cycle wins.
    assign cap_data = bus.io_ready ? bus.io_din : {64{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            io_addr_q  <= '0;
            io_dout_q  <= '0;
            io_write_q <= 1'b0;
            io_valid_q <= 1'b0;
            m0_din_q   <= '0;
            m1_din_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.m0_addr_valid || bus.m1_addr_valid) begin
                        grant_q    <= sel;
                        io_addr_q  <= sel ? bus.m1_addr : bus.m0_addr;
                        io_dout_q  <= sel ? bus.m1_dout : bus.m0_dout;
                        io_write_q <= sel ? bus.m1_dout_write : bus.m0_dout_write;
                        io_valid_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Captured on writes too, so the master always sees what the device returned.
                    if (bus.io_ready || abort) begin
                        io_valid_q <= 1'b0;
                        if (grant_q) begin
                            m1_din_q <= cap_data;
                        end else begin
                            m0_din_q <= cap_data;
                        end
                    end
                end
                DONE: begin
                    last_grant <= grant_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IO_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_first;

    assign abort = (state == ACTIVE) && !bus.io_ready && (tmo_cnt == TMO_LAST);

    // The first ACTIVE cycle is the clearing cycle; counting starts after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt    <= '0;
            tmo_first  <= 1'b1;
            err_flag_q <= 1'b0;
        end else begin
            if (state != ACTIVE) begin
                tmo_cnt   <= '0;
                tmo_first <= 1'b1;
            end else if (tmo_first) begin
                tmo_first <= 1'b0;
            end else if (!bus.io_ready) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            // Set has priority over clear.
            if (abort) begin
                err_flag_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_flag_q <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;

    assign abort          = 1'b0;
    assign err_flag_q     = 1'b0;
    assign unused_err_clr = bus.err_clr;
`endif

    assign bus.io_addr      = io_addr_q;
    assign bus.io_dout      = io_dout_q;
    assign bus.io_write     = io_write_q;
    assign bus.io_valid     = io_valid_q;
    assign bus.grant        = grant_q;
    assign bus.m0_din       = m0_din_q;
    assign bus.m1_din       = m1_din_q;
    assign bus.m0_din_ready = (state == DONE) && !grant_q;
    assign bus.m1_din_ready = (state == DONE) && grant_q;
    assign bus.err_flag     = err_flag_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - self-checking bench for io_bus_arbiter

module tb_io_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_bus_arbiter_if bus();

    io_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Device model: ready after dev_wait stall cycles; dev_wait < 0 never readies.
    int dev_wait = 0;
    int act_cycles = 0;
    always @(posedge clk) act_cycles <= bus.io_valid ? act_cycles + 1 : 0;
    assign bus.io_ready = bus.io_valid && (dev_wait >= 0) && (act_cycles == dev_wait);

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] model_din0 = '0;
    logic [63:0] model_din1 = '0;

    typedef struct {
        bit          rst_before;
        bit          req0;
        bit          wr0;
        logic [63:0] addr0;
        logic [63:0] dout0;
        bit          req1;
        bit          wr1;
        logic [63:0] addr1;
        logic [63:0] dout1;
        int          dev_wait;
        logic [63:0] io_din;
        bit          err_clr;
        bit          exp_grant;
        int          exp_lat;
        logic [63:0] exp_din;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t tvecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m0_addr       = '0;
        bus.m1_addr       = '0;
        bus.m0_dout       = '0;
        bus.m1_dout       = '0;
        bus.m0_addr_valid = 1'b0;
        bus.m1_addr_valid = 1'b0;
        bus.m0_dout_write = 1'b0;
        bus.m1_dout_write = 1'b0;
        bus.io_din        = '0;
        bus.err_clr       = 1'b0;
        dev_wait          = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_din0 = '0;
        model_din1 = '0;
    endtask

    // Entered and left 1 time unit after a posedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        bit          seen;
        logic [63:0] ea;
        logic [63:0] ed;
        logic        ew;
        if (v.rst_before) do_reset();
        bus.m0_addr       = v.addr0;
        bus.m0_dout       = v.dout0;
        bus.m0_dout_write = v.wr0;
        bus.m0_addr_valid = v.req0;
        bus.m1_addr       = v.addr1;
        bus.m1_dout       = v.dout1;
        bus.m1_dout_write = v.wr1;
        bus.m1_addr_valid = v.req1;
        bus.io_din        = v.io_din;
        bus.err_clr       = v.err_clr;
        dev_wait          = v.dev_wait;
        ea = v.exp_grant ? v.addr1 : v.addr0;
        ed = v.exp_grant ? v.dout1 : v.dout0;
        ew = v.exp_grant ? v.wr1 : v.wr0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat <= 40) begin
            @(negedge clk);
            if (bus.m0_din_ready || bus.m1_din_ready) begin
                seen = 1'b1;
            end else begin
                if (bus.io_valid) begin
                    check({tag, " io_addr"}, bus.io_addr, ea);
                    check({tag, " io_dout"}, bus.io_dout, ed);
                    check({tag, " io_write"}, 64'(bus.io_write), 64'(ew));
                end
                lat++;
                @(posedge clk);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s wait: no din_ready after %0d cycles, required %0d", tag, lat, v.exp_lat);
        end else begin
            check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
            check({tag, " grant"}, 64'(bus.grant), 64'(v.exp_grant));
            check({tag, " ready pair"}, 64'({bus.m1_din_ready, bus.m0_din_ready}),
                  v.exp_grant ? 64'd2 : 64'd1);
            check({tag, " io_valid"}, 64'(bus.io_valid), 64'd0);
            check({tag, " err_flag"}, 64'(bus.err_flag), 64'(v.exp_err));
            if (v.exp_grant) model_din1 = v.exp_din;
            else             model_din0 = v.exp_din;
            check({tag, " m0_din"}, bus.m0_din, model_din0);
            check({tag, " m1_din"}, bus.m1_din, model_din1);
        end
        if (v.exp_grant) bus.m1_addr_valid = 1'b0;
        else             bus.m0_addr_valid = 1'b0;
        bus.err_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err(input string tag);
        @(negedge clk);
        check({tag, " sticky err"}, 64'(bus.err_flag), 64'd1);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        check({tag, " err cleared"}, 64'(bus.err_flag), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             rst  r0  w0    addr0              dout0       r1  w1    addr1              dout1     wait io_din    clr   g    lat exp_din   err
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h8000_0010, 64'h0,      1'b0, 1'b0, 64'h0,          64'h0,      0, 64'h1234, 1'b0, 1'b0, 2, 64'h1234, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,         64'h0,      1'b1, 1'b1, 64'h8000_0000, 64'hBEEF,   3, 64'h5555, 1'b0, 1'b1, 5, 64'h5555, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 64'h8000_0100, 64'h0,      1'b1, 1'b1, 64'h8000_0200, 64'hCAFE,   1, 64'hA0,   1'b0, 1'b0, 3, 64'hA0,   1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h8000_0100, 64'h0,      1'b1, 1'b1, 64'h8000_0200, 64'hCAFE,   0, 64'hA1,   1'b0, 1'b1, 2, 64'hA1,   1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h8000_0108, 64'h1111,   1'b1, 1'b0, 64'h8000_0208, 64'h0,      2, 64'hA2,   1'b0, 1'b0, 4, 64'hA2,   1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h8000_0108, 64'h1111,   1'b1, 1'b0, 64'h8000_0208, 64'h0,      0, 64'hA3,   1'b0, 1'b1, 2, 64'hA3,   1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,         64'h0,      1'b1, 1'b0, 64'h8000_0300, 64'h0,      0, 64'hB7,   1'b0, 1'b1, 2, 64'hB7,   1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h8000_0018, 64'h0,      1'b0, 1'b0, 64'h0,          64'h0,      1, 64'hB8,   1'b1, 1'b0, 3, 64'hB8,   1'b0});
        // Timeout build: never-ready, never-ready with err_clr held, ready exactly at the abort cycle.
        tvecs.push_back('{1'b0, 1'b1, 1'b0, 64'h8000_0020, 64'h0,     1'b0, 1'b0, 64'h0,          64'h0,     -1, 64'h99,   1'b0, 1'b0, 10, {64{1'b1}}, 1'b1});
        tvecs.push_back('{1'b0, 1'b1, 1'b0, 64'h8000_0028, 64'h0,     1'b0, 1'b0, 64'h0,          64'h0,     -1, 64'h98,   1'b1, 1'b0, 10, {64{1'b1}}, 1'b1});
        tvecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,         64'h0,     1'b1, 1'b0, 64'h8000_0030, 64'h0,      8, 64'h77,   1'b0, 1'b1, 10, 64'h77,     1'b0});

        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset io_valid", 64'(bus.io_valid), 64'd0);
        check("reset io_write", 64'(bus.io_write), 64'd0);
        check("reset io_addr", bus.io_addr, 64'd0);
        check("reset io_dout", bus.io_dout, 64'd0);
        check("reset grant", 64'(bus.grant), 64'd0);
        check("reset din_ready", 64'({bus.m1_din_ready, bus.m0_din_ready}), 64'd0);
        check("reset m0_din", bus.m0_din, 64'd0);
        check("reset m1_din", bus.m1_din, 64'd0);
        check("reset err_flag", 64'(bus.err_flag), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during ACTIVE: last access went to m0, so m1 wins this contention and is then dropped.
        bus.m0_addr       = 64'h8000_0040;
        bus.m1_addr       = 64'h8000_0048;
        bus.m0_addr_valid = 1'b1;
        bus.m1_addr_valid = 1'b1;
        dev_wait          = -1;
        @(negedge clk);
        @(negedge clk);
        check("midrst active", 64'(bus.io_valid), 64'd1);
        check("midrst grant", 64'(bus.grant), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.m0_addr_valid = 1'b0;
        bus.m1_addr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_din0 = '0;
        model_din1 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("midrst ready c%0d", k), 64'({bus.m1_din_ready, bus.m0_din_ready}), 64'd0);
            check($sformatf("midrst io_valid c%0d", k), 64'(bus.io_valid), 64'd0);
        end
        check("midrst io_addr", bus.io_addr, 64'd0);
        check("midrst m1_din", bus.m1_din, 64'd0);
        @(posedge clk);
        #1;
        run_vec('{1'b0, 1'b1, 1'b0, 64'h8000_0050, 64'h0, 1'b1, 1'b0, 64'h8000_0058, 64'h0,
                  0, 64'hC0, 1'b0, 1'b0, 2, 64'hC0, 1'b0}, "postrst");

`ifdef IO_BUS_ARB_TIMEOUT_EN
        run_vec(tvecs[0], "tmo0");
        clear_err("tmo0");
        run_vec(tvecs[1], "tmo1");
        clear_err("tmo1");
        run_vec(tvecs[2], "tmo2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
